// File: rtl/storage_chk_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// storage_chk_pkg: shared FSM state type, default sizes and saturating increment
// Rev 1.0
// ----------------------------------------------------------------------------
package storage_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    CMP  = 2'd2
  } chk_state_t;

  localparam int DEF_SETTLE = 2;
  localparam int DEF_CNT_W  = 8;

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] lim);
    return (val >= lim) ? val : val + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/edge_capture_checker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// edge_capture_checker: waits SETTLE cycles after an edge, then compares q
// Rev 1.0
// ----------------------------------------------------------------------------
module edge_capture_checker
  import storage_chk_pkg::*;
#(
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic trig,
  input  logic d_exp,
  input  logic q,
  output logic err,
  output logic busy
);

  localparam logic [2:0] SETTLE_V = 3'(SETTLE);

  chk_state_t state;
  chk_state_t state_nxt;
  logic [2:0] timer;
  logic [2:0] timer_nxt;
  logic       exp_val;
  logic       exp_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= 3'd0;
      exp_val <= 1'b0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      exp_val <= exp_nxt;
    end
  end

  // A new trigger always restarts, silently dropping any compare in flight.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    exp_nxt   = exp_val;
    if (!en) begin
      state_nxt = IDLE;
      timer_nxt = 3'd0;
    end else if (trig) begin
      state_nxt = WAIT;
      timer_nxt = SETTLE_V;
      exp_nxt   = d_exp;
    end else begin
      case (state)
        WAIT: begin
          timer_nxt = timer - 3'd1;
          if (timer == 3'd1) state_nxt = CMP;
        end
        CMP:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    err  = (state == CMP) && en && !trig && (q != exp_val);
    busy = (state != IDLE);
  end

endmodule
`default_nettype wire

// File: rtl/storage_ele_checker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// storage_ele_checker: oversampling monitor for a latch, a posedge FF and a negedge FF
// Rev 1.0
// ----------------------------------------------------------------------------
module storage_ele_checker
  import storage_chk_pkg::*;
#(
  parameter int SETTLE = DEF_SETTLE,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             eclk,
  input  logic             d,
  input  logic             qa,
  input  logic             qb,
  input  logic             qc,
  output logic             err_a,
  output logic             err_b,
  output logic             err_c,
  output logic [CNT_W-1:0] err_cnt_a,
  output logic [CNT_W-1:0] err_cnt_b,
  output logic [CNT_W-1:0] err_cnt_c,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             busy
);

  localparam logic [2:0]  SETTLE_V = 3'(SETTLE);
  localparam logic [31:0] CNT_MAX  = (32'd1 << CNT_W) - 32'd1;

  logic       eclk_q;
  logic       d_q;
  logic       primed;
  logic       rise;
  logic       fall;
  logic       stable;
  logic [2:0] stab;
  logic       hold;
  logic       hold_valid;
  logic       mis_a;
  logic       err_pulse_b;
  logic       err_pulse_c;
  logic       busy_b;
  logic       busy_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      eclk_q <= 1'b0;
      d_q    <= 1'b0;
      primed <= 1'b0;
    end else begin
      eclk_q <= eclk;
      d_q    <= d;
      primed <= 1'b1;
    end
  end

  // History is meaningless until one real sample has been taken after reset.
  assign rise   = primed &  eclk & ~eclk_q;
  assign fall   = primed & ~eclk &  eclk_q;
  assign stable = primed & (d == d_q) & (eclk == eclk_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      stab       <= 3'd0;
      hold       <= 1'b0;
      hold_valid <= 1'b0;
    end else begin
      if (!stable)               stab <= 3'd0;
      else if (stab != SETTLE_V) stab <= stab + 3'd1;
      if (fall) begin
        hold       <= d_q;
        hold_valid <= 1'b1;
      end
    end
  end

  assign mis_a = en & hold_valid & stable & (stab == SETTLE_V) & (qa != (eclk ? d : hold));

  edge_capture_checker #(.SETTLE(SETTLE)) u_chk_b (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .trig  (rise),
    .d_exp (d_q),
    .q     (qb),
    .err   (err_pulse_b),
    .busy  (busy_b)
  );

  edge_capture_checker #(.SETTLE(SETTLE)) u_chk_c (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .trig  (fall),
    .d_exp (d_q),
    .q     (qc),
    .err   (err_pulse_c),
    .busy  (busy_c)
  );

  assign busy = busy_b | busy_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_a     <= 1'b0;
      err_b     <= 1'b0;
      err_c     <= 1'b0;
      err_cnt_a <= '0;
      err_cnt_b <= '0;
      err_cnt_c <= '0;
      edge_cnt  <= '0;
    end else begin
      if (mis_a) begin
        err_a     <= 1'b1;
        err_cnt_a <= CNT_W'(sat_inc(32'(err_cnt_a), CNT_MAX));
      end
      if (err_pulse_b) begin
        err_b     <= 1'b1;
        err_cnt_b <= CNT_W'(sat_inc(32'(err_cnt_b), CNT_MAX));
      end
      if (err_pulse_c) begin
        err_c     <= 1'b1;
        err_cnt_c <= CNT_W'(sat_inc(32'(err_cnt_c), CNT_MAX));
      end
      if (rise && en) begin
        edge_cnt  <= CNT_W'(sat_inc(32'(edge_cnt), CNT_MAX));
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_storage_ele_checker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_storage_ele_checker: directed stimulus with a queued scoreboard of expected outputs
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_storage_ele_checker;

  localparam int SETTLE = 2;
  localparam int CNT_W  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  logic eclk = 1'b0;
  logic d = 1'b0;
  logic qa;
  logic qb;
  logic qc;
  logic err_a;
  logic err_b;
  logic err_c;
  logic [CNT_W-1:0] err_cnt_a;
  logic [CNT_W-1:0] err_cnt_b;
  logic [CNT_W-1:0] err_cnt_c;
  logic [CNT_W-1:0] edge_cnt;
  logic busy;

  // Element models plus fault selectors
  logic qb_m = 1'b0;
  logic qc_m = 1'b0;
  logic la_hold = 1'b0;
  logic qa_mode = 1'b0;
  logic qb_mode = 1'b0;
  logic qc_mode = 1'b0;

  storage_ele_checker #(.SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .eclk      (eclk),
    .d         (d),
    .qa        (qa),
    .qb        (qb),
    .qc        (qc),
    .err_a     (err_a),
    .err_b     (err_b),
    .err_c     (err_c),
    .err_cnt_a (err_cnt_a),
    .err_cnt_b (err_cnt_b),
    .err_cnt_c (err_cnt_c),
    .edge_cnt  (edge_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge eclk) qb_m <= d;
  always @(negedge eclk) begin
    qc_m    <= d;
    la_hold <= d;
  end

  always_comb begin
    qa = eclk ? (qa_mode ? 1'b0 : d) : la_hold;
    qb = qb_mode ? 1'b0 : qb_m;
    qc = qc_mode ? qb_m : qc_m;
  end

  typedef struct {
    logic [127:0] tag;
    logic         ea;
    logic         eb;
    logic         ec;
    logic [7:0]   ca;
    logic [7:0]   cb;
    logic [7:0]   cc;
    logic [7:0]   ecnt;
    logic         bsy;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic expect_out(input logic [127:0] tag, input logic ea, input logic eb,
                            input logic ec, input logic [7:0] ca, input logic [7:0] cb,
                            input logic [7:0] cc, input logic [7:0] ecnt, input logic bsy);
    exp_t e;
    e.tag = tag; e.ea = ea; e.eb = eb; e.ec = ec;
    e.ca = ca; e.cb = cb; e.cc = cc; e.ecnt = ecnt; e.bsy = bsy;
    sbq.push_back(e);
  endtask

  task automatic cmp(input logic [127:0] tag, input logic [63:0] fld,
                     input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %0s.%0s: actual %0d required %0d", tag, fld, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sbq.size() != 0) begin
      mon_e = sbq.pop_front();
      cmp(mon_e.tag, "err_a", {7'd0, err_a}, {7'd0, mon_e.ea});
      cmp(mon_e.tag, "err_b", {7'd0, err_b}, {7'd0, mon_e.eb});
      cmp(mon_e.tag, "err_c", {7'd0, err_c}, {7'd0, mon_e.ec});
      cmp(mon_e.tag, "cnt_a", err_cnt_a, mon_e.ca);
      cmp(mon_e.tag, "cnt_b", err_cnt_b, mon_e.cb);
      cmp(mon_e.tag, "cnt_c", err_cnt_c, mon_e.cc);
      cmp(mon_e.tag, "edges", edge_cnt, mon_e.ecnt);
      cmp(mon_e.tag, "busy", {7'd0, busy}, {7'd0, mon_e.bsy});
    end
  end

  // One element-clock half-period: 10 clk, d updated mid-phase only.
  task automatic half(input logic lvl, input logic dmid);
    @(negedge clk); eclk = lvl;
    repeat (5) @(negedge clk);
    d = dmid;
    repeat (4) @(negedge clk);
  endtask

  task automatic period(input logic dh, input logic dl);
    half(1'b1, dh);
    half(1'b0, dl);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    expect_out("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);

    period(1, 1); period(0, 0); period(0, 1); period(1, 0); period(1, 1);
    expect_out("clean", 0, 0, 0, 0, 0, 0, 5, 0);

    qb_mode = 1'b1;
    period(1, 1); period(1, 1); period(1, 1);
    expect_out("qb_stuck", 0, 1, 0, 0, 3, 0, 8, 0);

    qb_mode = 1'b0; qc_mode = 1'b1;
    period(0, 0); period(1, 1); period(0, 0);
    expect_out("qc_wrong_edge", 0, 1, 1, 0, 3, 3, 11, 0);

    qc_mode = 1'b0; qb_mode = 1'b1;
    half(0, 1);
    @(negedge clk); eclk = 1'b1;
    @(negedge clk); expect_out("pre_reset_busy", 0, 1, 1, 0, 3, 3, 12, 1);
    @(negedge clk); rst = 1'b1; expect_out("reset_mid_cmp", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); rst = 1'b0;
    repeat (7) @(negedge clk);
    half(0, 1);
    expect_out("post_reset", 0, 0, 0, 0, 0, 0, 0, 0);

    en = 1'b0;
    period(1, 1); period(1, 1);
    expect_out("en_off", 0, 0, 0, 0, 0, 0, 0, 0);
    en = 1'b1;
    period(1, 1);
    expect_out("en_resume", 0, 1, 0, 0, 1, 0, 1, 0);

    qb_mode = 1'b0; qa_mode = 1'b1;
    period(1, 1);
    expect_out("qa_transp", 1, 1, 0, 7, 1, 0, 2, 0);
    repeat (35) period(1, 1);
    expect_out("qa_252", 1, 1, 0, 252, 1, 0, 37, 0);
    period(1, 1);
    expect_out("qa_sat", 1, 1, 0, 255, 1, 0, 38, 0);
    period(1, 1);
    expect_out("qa_sat_hold", 1, 1, 0, 255, 1, 0, 39, 0);

    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: actual %0d pending required 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
